operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage of the RV32I pipeline, directly upstream of the register file; drives the regfile read addresses and consumes its two combinational read ports.
- Accepts one instruction per cycle from fetch via a valid/ready handshake and decodes fields and the immediate.
- Produces registered operands into the ID/EX pipeline register, with x0 forcing, write-back bypass, load-use stall and flush.

Parameters:
- XLEN, 32, operand/data width; must match the regfile word size.
- PC_W, 32, program-counter width.

Ports:
- clk  in  1  rising-edge clock, shared with the regfile.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction address.
- rf_addr1  out  5  regfile read address 1; combinational from in_instr[19:15].
- rf_addr2  out  5  regfile read address 2; combinational from in_instr[24:20].
- rf_data1  in  XLEN  regfile read data 1.
- rf_data2  in  XLEN  regfile read data 2.
- wb_wr  in  1  write-back write enable; same signal that drives the regfile write port.
- wb_addr  in  5  write-back destination.
- wb_data  in  XLEN  write-back data.
- ex_is_load  in  1  EX holds a valid load.
- ex_rd  in  5  EX destination register.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX accepts.
- out_pc  out  PC_W  registered PC.
- out_rs1_val  out  XLEN  registered operand 1.
- out_rs2_val  out  XLEN  registered operand 2.
- out_rs1, out_rs2, out_rd  out  5 each  registered register indices, used by EX forwarding.
- out_imm  out  XLEN  sign-extended immediate.
- out_opcode  out  7  instruction opcode.
- out_funct3  out  3  instruction funct3.
- out_funct7b5  out  1  instruction bit 30.
- out_illegal  out  1  opcode not in the RV32I base set.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0; every registered output is 0.
- Operand usage:
  - use_rs1: every opcode except LUI, AUIPC, JAL.
  - use_rs2: OP, STORE, BRANCH.
- Load-use hazard: hz = in_valid & ex_is_load & ex_rd!=0 & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd)).
- in_ready = (!out_valid | out_ready) & !hz & !flush.
- Capture on in_valid & in_ready; 1-cycle latency, with the result visible the cycle after acceptance.
- If out_ready=1 and nothing is captured (hz, flush or no input), out_valid goes to 0 (bubble).
- Operand select, priority order:
  - rs==0 gives 0. The regfile does not hardwire x0.
  - Otherwise wb_wr & wb_addr==rs gives wb_data. The regfile write lands at the same edge, so the read port still shows the old value.
  - Otherwise rf_dataN.
- Hold-snoop: while out_valid & !out_ready, if wb_wr & wb_addr!=0 & wb_addr==out_rs1, update out_rs1_val to wb_data; out_rs2 is handled the same way. Both may update in the same cycle.
- Immediate formats (all results sign-extended to XLEN):
  - I: LOAD, OP-IMM, JALR.
  - S: STORE.
  - B: BRANCH, with bit0=0.
  - U: LUI, AUIPC, as {instr[31:12],12'b0}.
  - J: JAL, with bit0=0.
  - OP gives 0.
  - Unknown opcode gives imm=0 and out_illegal=1; it is still passed downstream.
- Flush (synchronous): the next edge sets out_valid=0 and nothing is captured. Flush overrides capture and hold.
- Simultaneous hz and out_ready=1: a bubble is emitted and the fetch instruction waits.
- Reset asserted mid-stall discards all state immediately.

Decomposition:
- Shared package rv32_pkg:
  - opcode constants: OPC_LOAD 0000011, OPC_OPIMM 0010011, OPC_AUIPC 0010111, OPC_STORE 0100011, OPC_OP 0110011, OPC_LUI 0110111, OPC_BRANCH 1100011, OPC_JALR 1100111, OPC_JAL 1101111.
  - imm_fmt_t enum: I, S, B, U, J, NONE.
  - XLEN default.
- Sub-module imm_gen: purely combinational; maps instr to imm and illegal.

Test Plan:
- Release reset, then send addi x5,x0,-1 (0xFFF00293) with out_ready=1 -> next cycle out_valid=1, out_rs1_val=0, out_imm=0xFFFFFFFF, out_rd=5.
- Regfile x3=7; send add x4,x3,x3 with wb_wr=1, wb_addr=3, wb_data=0x55 in the same cycle -> out_rs1_val=out_rs2_val=0x55.
- ex_is_load=1, ex_rd=6; present sub x1,x6,x2 -> in_ready=0 and out_valid=0 next cycle. Drop ex_is_load -> accepted the following cycle.
- Hold with out_ready=0 and out_rs2=9; pulse wb_wr with addr 9, data 0xA5 -> out_rs2_val=0xA5 while held, released intact when out_ready=1.
- jal x1,+2048 (0x001000EF) -> out_imm=0x00000800. beq with offset -4 -> out_imm=0xFFFFFFFC. Opcode 0x7F -> out_illegal=1.
- flush together with in_valid and a held instruction -> out_valid=0 next cycle and nothing captured. Pulse rst low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I opcode constants, immediate formats and decode helpers
package rv32_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_t;

  function automatic imm_fmt_t imm_fmt(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: return IMM_I;
      OPC_STORE:                     return IMM_S;
      OPC_BRANCH:                    return IMM_B;
      OPC_LUI, OPC_AUIPC:            return IMM_U;
      OPC_JAL:                       return IMM_J;
      default:                       return IMM_NONE;
    endcase
  endfunction

  function automatic logic opc_legal(input logic [6:0] opc);
    return (imm_fmt(opc) != IMM_NONE) || (opc == OPC_OP);
  endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// rtl/operand_fetch_stage_if.sv - ID/EX pipeline register bus between decode and execute
interface operand_fetch_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic            out_funct7b5;
  logic            out_illegal;

  modport master (
    output out_valid, out_pc, out_rs1_val, out_rs2_val, out_rs1, out_rs2, out_rd,
           out_imm, out_opcode, out_funct3, out_funct7b5, out_illegal,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pc, out_rs1_val, out_rs2_val, out_rs1, out_rs2, out_rd,
           out_imm, out_opcode, out_funct3, out_funct7b5, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate extraction and illegal-opcode detect
module imm_gen
  import rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  imm_fmt_t    fmt;
  logic [31:0] imm32;

  always_comb begin
    fmt     = imm_fmt(instr[6:0]);
    illegal = !opc_legal(instr[6:0]);
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - RV32I decode/operand fetch with x0 forcing, WB bypass,
// load-use stall, flush and hold-snoop into the ID/EX register
module operand_fetch_stage
  import rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int PC_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [PC_W-1:0]              in_pc,
  output logic [4:0]                   rf_addr1,
  output logic [4:0]                   rf_addr2,
  input  logic [XLEN-1:0]              rf_data1,
  input  logic [XLEN-1:0]              rf_data2,
  input  logic                         wb_wr,
  input  logic [4:0]                   wb_addr,
  input  logic [XLEN-1:0]              wb_data,
  input  logic                         ex_is_load,
  input  logic [4:0]                   ex_rd,
  input  logic                         flush,
  operand_fetch_stage_if.master        idex
);

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2;
  logic            use_rs1, use_rs2, hz, capture;
  logic [XLEN-1:0] imm, op1, op2;
  logic            illegal;

  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d, imm_q, imm_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            f7b5_q, f7b5_d, illegal_q, illegal_d;

  assign opcode   = in_instr[6:0];
  assign rs1      = in_instr[19:15];
  assign rs2      = in_instr[24:20];
  assign rf_addr1 = rs1;
  assign rf_addr2 = rs2;

  assign use_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign use_rs2 = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};

  assign hz = in_valid && ex_is_load && (ex_rd != 5'd0) &&
              ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));
  assign in_ready = (!valid_q || idex.out_ready) && !hz && !flush;
  assign capture  = in_valid && in_ready;

  // The regfile is written on the same edge we sample, so its read port is stale.
  assign op1 = (rs1 == 5'd0) ? '0 : (wb_wr && wb_addr == rs1) ? wb_data : rf_data1;
  assign op2 = (rs2 == 5'd0) ? '0 : (wb_wr && wb_addr == rs2) ? wb_data : rf_data2;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (in_instr),
    .imm     (imm),
    .illegal (illegal)
  );

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    f7b5_d    = f7b5_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d   = 1'b1;
      pc_d      = in_pc;
      rs1_val_d = op1;
      rs2_val_d = op2;
      rs1_d     = rs1;
      rs2_d     = rs2;
      rd_d      = in_instr[11:7];
      imm_d     = imm;
      opcode_d  = opcode;
      funct3_d  = in_instr[14:12];
      f7b5_d    = in_instr[30];
      illegal_d = illegal;
    end else if (!valid_q || idex.out_ready) begin
      valid_d = 1'b0;
    end else begin
      // Held instruction keeps tracking write-back so it leaves with fresh operands.
      if (wb_wr && wb_addr != 5'd0 && wb_addr == rs1_q) rs1_val_d = wb_data;
      if (wb_wr && wb_addr != 5'd0 && wb_addr == rs2_q) rs2_val_d = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      f7b5_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      f7b5_q    <= f7b5_d;
      illegal_q <= illegal_d;
    end
  end

  assign idex.out_valid    = valid_q;
  assign idex.out_pc       = pc_q;
  assign idex.out_rs1_val  = rs1_val_q;
  assign idex.out_rs2_val  = rs2_val_q;
  assign idex.out_rs1      = rs1_q;
  assign idex.out_rs2      = rs2_q;
  assign idex.out_rd       = rd_q;
  assign idex.out_imm      = imm_q;
  assign idex.out_opcode   = opcode_q;
  assign idex.out_funct3   = funct3_q;
  assign idex.out_funct7b5 = f7b5_q;
  assign idex.out_illegal  = illegal_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - directed self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_addr1, rf_addr2;
  logic [31:0] rf_data1, rf_data2;
  logic        wb_wr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        flush;
  logic [31:0] regs [32];
  int          checks = 0;
  int          errors = 0;

  operand_fetch_stage_if #(.XLEN(32), .PC_W(32)) idex ();

  operand_fetch_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .rf_addr1   (rf_addr1),
    .rf_addr2   (rf_addr2),
    .rf_data1   (rf_data1),
    .rf_data2   (rf_data2),
    .wb_wr      (wb_wr),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .flush      (flush),
    .idex       (idex)
  );

  always #5 clk = ~clk;

  // Regfile model: x0 deliberately non-zero, write lands on the clock edge.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == 0) ? 32'hDEADBEEF : (i == 3) ? 32'd7 : 32'h100 + 32'(i);
    end else if (wb_wr) begin
      regs[wb_addr] <= wb_data;
    end
  end
  assign rf_data1 = regs[rf_addr1];
  assign rf_data2 = regs[rf_addr2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_wr = 1'b0; wb_addr = '0; wb_data = '0;
    ex_is_load = 1'b0; ex_rd = '0; flush = 1'b0; idex.out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(idex.out_valid), 32'd0);
    check("rst_pc", idex.out_pc, 32'd0);
    check("rst_imm", idex.out_imm, 32'd0);
    check("rst_rs1_val", idex.out_rs1_val, 32'd0);
    rst = 1'b1;

    // addi x5,x0,-1 with a load to x0 in EX: no hazard, x0 forced to 0
    in_valid = 1'b1; in_instr = 32'hFFF00293; in_pc = 32'h100;
    ex_is_load = 1'b1; ex_rd = 5'd0;
    #1 check("ready_exrd0", 32'(in_ready), 32'd1);
    tick();
    check("addi_valid", 32'(idex.out_valid), 32'd1);
    check("addi_rs1_val", idex.out_rs1_val, 32'd0);
    check("addi_imm", idex.out_imm, 32'hFFFFFFFF);
    check("addi_rd", 32'(idex.out_rd), 32'd5);
    check("addi_pc", idex.out_pc, 32'h100);
    check("addi_opcode", 32'(idex.out_opcode), 32'h13);

    // add x4,x3,x3 with same-cycle write-back to x3
    ex_is_load = 1'b0;
    in_instr = 32'h00318233; in_pc = 32'h104;
    wb_wr = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    tick();
    wb_wr = 1'b0;
    check("byp_rs1_val", idex.out_rs1_val, 32'h55);
    check("byp_rs2_val", idex.out_rs2_val, 32'h55);
    check("byp_rd", 32'(idex.out_rd), 32'd4);

    // sub x1,x6,x2 behind a load to x6
    ex_is_load = 1'b1; ex_rd = 5'd6;
    in_instr = 32'h402300B3; in_pc = 32'h108;
    #1 check("hz_ready", 32'(in_ready), 32'd0);
    tick();
    check("hz_bubble", 32'(idex.out_valid), 32'd0);
    ex_is_load = 1'b0;
    #1 check("hz_clear_ready", 32'(in_ready), 32'd1);
    tick();
    check("sub_valid", 32'(idex.out_valid), 32'd1);
    check("sub_rs1", 32'(idex.out_rs1), 32'd6);
    check("sub_rs1_val", idex.out_rs1_val, 32'h106);
    check("sub_rs2_val", idex.out_rs2_val, 32'h102);
    check("sub_f7b5", 32'(idex.out_funct7b5), 32'd1);
    check("sub_pc", idex.out_pc, 32'h108);

    // add x10,x8,x9 held, write-back to x9 snooped
    in_instr = 32'h00940533; in_pc = 32'h10C;
    tick();
    check("hold_rs2", 32'(idex.out_rs2), 32'd9);
    idex.out_ready = 1'b0;
    in_instr = 32'h0020A423; in_pc = 32'h110;
    wb_wr = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5;
    #1 check("hold_ready", 32'(in_ready), 32'd0);
    tick();
    wb_wr = 1'b0;
    check("hold_valid", 32'(idex.out_valid), 32'd1);
    check("snoop_rs2_val", idex.out_rs2_val, 32'hA5);
    check("snoop_rs1_val", idex.out_rs1_val, 32'h108);
    check("hold_pc", idex.out_pc, 32'h10C);
    idex.out_ready = 1'b1;
    #1 check("release_rs2_val", idex.out_rs2_val, 32'hA5);
    check("release_ready", 32'(in_ready), 32'd1);
    tick();
    check("sw_imm", idex.out_imm, 32'd8);
    check("sw_rs1_val", idex.out_rs1_val, 32'h101);
    check("sw_rs2_val", idex.out_rs2_val, 32'h102);
    check("sw_funct3", 32'(idex.out_funct3), 32'd2);

    // jal x1,+2048
    in_instr = 32'h001000EF; in_pc = 32'h200;
    tick();
    check("jal_imm", idex.out_imm, 32'h800);
    check("jal_rd", 32'(idex.out_rd), 32'd1);

    // lui x7,0x12345: rs1 field is 8 but unused, so a load to x8 does not stall
    ex_is_load = 1'b1; ex_rd = 5'd8;
    in_instr = 32'h123453B7; in_pc = 32'h204;
    #1 check("lui_ready", 32'(in_ready), 32'd1);
    tick();
    ex_is_load = 1'b0;
    check("lui_imm", idex.out_imm, 32'h12345000);

    // beq x0,x0,-4
    in_instr = 32'hFE000EE3; in_pc = 32'h208;
    tick();
    check("beq_imm", idex.out_imm, 32'hFFFFFFFC);
    check("beq_illegal", 32'(idex.out_illegal), 32'd0);

    // opcode 0x7F
    in_instr = 32'h0000007F; in_pc = 32'h20C;
    tick();
    check("ill_valid", 32'(idex.out_valid), 32'd1);
    check("ill_flag", 32'(idex.out_illegal), 32'd1);
    check("ill_imm", idex.out_imm, 32'd0);

    // flush with held instruction and a new one offered
    idex.out_ready = 1'b0; flush = 1'b1;
    in_instr = 32'hFFF00293; in_pc = 32'h300;
    #1 check("flush_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    check("flush_valid", 32'(idex.out_valid), 32'd0);
    check("flush_pc", idex.out_pc, 32'h20C);

    // stall with a held instruction, then asynchronous reset mid-cycle
    in_pc = 32'h400;
    tick();
    check("pre_rst_valid", 32'(idex.out_valid), 32'd1);
    ex_is_load = 1'b1; ex_rd = 5'd3;
    in_instr = 32'h00318233; in_pc = 32'h404;
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(idex.out_valid), 32'd0);
    check("arst_pc", idex.out_pc, 32'd0);
    check("arst_imm", idex.out_imm, 32'd0);
    check("arst_rd", 32'(idex.out_rd), 32'd0);
    in_valid = 1'b0; ex_is_load = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
